// File: rtl/mem_data_ram.sv
// Single-port word RAM with a valid/ready request channel and one-deep response.
// Optional macro MEM_CLEAR_EN: zero every word during INIT after reset release.
module mem_data_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_W     = 16,
    parameter int BASE_ADDR  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteen,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   readdata,
    output logic                rsp_err,
    output logic                init_done
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WORDS = 2 ** DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     mem [WORDS];
    logic [ADDR_W:0]       diff;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  bad;
    logic                  accept;
    logic                  wr_en;
    logic                  init_last;

    // One extra bit so an address below BASE_ADDR shows up as a set MSB.
    assign diff   = {1'b0, address} - (ADDR_W + 1)'(BASE_ADDR);
    assign idx    = diff[OFF_W +: DEPTH_LOG2];
    assign bad    = (|(diff >> (OFF_W + DEPTH_LOG2)))
                 || (|(address & ALIGN_MASK));
    assign accept = req_valid && (state_q == IDLE);
    assign wr_en  = accept && req_write && !bad;

`ifdef MEM_CLEAR_EN
    logic [DEPTH_LOG2-1:0] clr_q, clr_d;

    assign clr_d     = (state_q == INIT) ? clr_q + 1'b1 : '0;
    assign init_last = &clr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_q <= '0;
        end else begin
            clr_q <= clr_d;
        end
    end
`else
    assign init_last = 1'b1;
`endif

    // Storage carries no reset; only INIT clearing or writes change it.
    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_EN
        if (state_q == INIT) begin
            mem[clr_q] <= '0;
        end else
`endif
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteen[b]) begin
                    mem[idx][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            INIT: begin
                if (init_last) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    err_d   = bad;
                    rdata_d = (!req_write && !bad) ? mem[idx] : '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign init_done = (state_q != INIT);
    assign readdata  = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/mem_data_ram.md
MEM_DATA_RAM -- requirements
Module: mem_data_ram

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH_LOG2, 8, log2 of the number of words.
- ADDR_W, 16, width of the byte address.
- BASE_ADDR, 1024, byte address of word 0.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, block accepts a request this cycle.
- req_write, in, 1, 1 = write, 0 = read.
- address, in, ADDR_W, byte address.
- writedata, in, DATA_W, write data.
- byteen, in, DATA_W/8, per-byte write enable.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, consumer takes the response.
- readdata, out, DATA_W, read result.
- rsp_err, out, 1, request was rejected.
- init_done, out, 1, memory is usable.

Function
REQ-003 A request SHALL be accepted on the rising edge where req_valid and req_ready are both 1.
REQ-004 Index SHALL be (address - BASE_ADDR) >> log2(DATA_W/8), computed at ADDR_W+1 bits so an address below BASE_ADDR goes negative.
REQ-005 A request SHALL be in error if the address is below BASE_ADDR, the index is at or above 2^DEPTH_LOG2, or the low log2(DATA_W/8) address bits are nonzero.
REQ-006 An accepted valid write SHALL update only the bytes whose byteen bit is 1, in the same edge it is accepted.
REQ-007 An accepted write with byteen all zero SHALL leave memory unchanged and still respond with rsp_err=0.
REQ-008 A write in error SHALL leave memory unchanged.
REQ-009 Every accepted request SHALL produce exactly one response, with rsp_valid=1 in the cycle after acceptance.
REQ-010 Read response: readdata = stored word, rsp_err=0. Write response: readdata=0. Any error response: readdata=0, rsp_err=1.
REQ-011 The FSM SHALL have three states: INIT, IDLE, RESP.
- INIT -> IDLE when initialisation completes.
- IDLE -> RESP on request acceptance.
- RESP -> IDLE when rsp_ready=1.
REQ-012 req_ready SHALL be 1 only in IDLE; at most one request is outstanding.
REQ-013 While rsp_valid=1 and rsp_ready=0, readdata and rsp_err SHALL hold stable.
REQ-014 A read of a word written by an earlier accepted request SHALL return the new data; no stale data.
REQ-015 init_done SHALL be 0 in INIT and 1 otherwise.

Reset
REQ-016 Asserting rst=0 SHALL immediately set: state=INIT, rsp_valid=0, rsp_err=0, readdata=0, req_ready=0, init_done=0.
REQ-017 Reset mid-transaction SHALL discard any pending response, with no response after release.
REQ-018 Memory contents SHALL NOT be affected by reset alone (see REQ-019).

Configuration
REQ-019 With macro MEM_CLEAR_EN defined, INIT SHALL write zero to one word per cycle, index 0 to 2^DEPTH_LOG2-1, then enter IDLE. Total INIT time is 2^DEPTH_LOG2 cycles after rst release.
REQ-020 Without MEM_CLEAR_EN, INIT SHALL last exactly one cycle after rst release, and memory contents SHALL be undefined until written.

Verification
REQ-021 Write 0xDEADBEEF @1024, byteen=4'hF, then read @1024. Required: read response readdata=0xDEADBEEF, rsp_err=0.
REQ-022 Write 0x11223344 @2044, then write 0xAABBCCDD @2044 with byteen=4'b0101, then read @2044. Required: readdata=0x11BB33DD.
REQ-023 Each of the following SHALL give rsp_err=1 and readdata=0, and a following read @1024 SHALL be unchanged:
- read @2048;
- write @1020;
- read @1026.
REQ-024 Read, then hold rsp_ready=0 for 5 cycles. Required: rsp_valid, readdata and rsp_err stable, req_ready=0 throughout; IDLE on the cycle after rsp_ready=1.
REQ-025 With MEM_CLEAR_EN, reset. Required: init_done rises exactly 256 cycles after release, and a read @1536 returns 0.
REQ-026 Assert rst=0 while in RESP. Required: rsp_valid falls immediately, and no response appears after release.
